// File: rtl/exu_mc_if.sv
// Issue/result handshake bundle for the multi-cycle execute unit.
//   master : drives the issue request (in_valid, op, src_sel, rs1, rs2, imm)
//            and the result acceptance (out_ready); observes in_ready,
//            out_valid, result and busy.
//   slave  : the execute unit itself.
interface exu_mc_if #(
    parameter int XLEN = 32
);
    logic            in_valid;
    logic            in_ready;
    logic [3:0]      op;
    logic            src_sel;
    logic [XLEN-1:0] rs1;
    logic [XLEN-1:0] rs2;
    logic [XLEN-1:0] imm;
    logic            out_valid;
    logic            out_ready;
    logic [XLEN-1:0] result;
    logic            busy;

    modport master (
        output in_valid, op, src_sel, rs1, rs2, imm, out_ready,
        input  in_ready, out_valid, result, busy
    );

    modport slave (
        input  in_valid, op, src_sel, rs1, rs2, imm, out_ready,
        output in_ready, out_valid, result, busy
    );
endinterface

// File: rtl/exu_mc.sv
// Multi-cycle execute unit.
// ALU ops (0-9) complete in one cycle; MUL/MULHU and DIVU/REMU/DIV/REM run
// an iterative shift-add / restoring-divide loop of XLEN cycles.
// Ports:
//   clk  - clock, rising edge
//   rst  - asynchronous active-high reset
//   bus  - exu_mc_if.slave: issue handshake (in_valid/in_ready, op, src_sel,
//          rs1, rs2, imm), result handshake (out_valid/out_ready, result),
//          busy status.
module exu_mc #(
    parameter int XLEN   = 32,
    parameter int SHW    = $clog2(XLEN),
    parameter bit MDU_EN = 1'b1
) (
    input  logic     clk,
    input  logic     rst,
    exu_mc_if.slave  bus
);

    localparam int CW = $clog2(XLEN);
    localparam logic [XLEN-1:0] MIN_VAL  = {1'b1, {(XLEN-1){1'b0}}};
    localparam logic [XLEN-1:0] ONES_VAL = {XLEN{1'b1}};

    typedef enum logic [1:0] {
        S_IDLE,
        S_BUSY,
        S_DONE
    } state_t;

    state_t          state_reg,  state_next;
    logic [XLEN-1:0] result_reg, result_next;
    logic [CW-1:0]   count_reg,  count_next;
    // Shared iteration registers: for multiply acc_hi/acc_lo hold the
    // partial product (acc_lo starts as the multiplier); for divide acc_hi is
    // the partial remainder and acc_lo shifts the dividend out / quotient in.
    logic [XLEN-1:0] acc_hi_reg, acc_hi_next;
    logic [XLEN-1:0] acc_lo_reg, acc_lo_next;
    logic [XLEN-1:0] opnd_reg,   opnd_next;
    logic [3:0]      op_reg,     op_next;
    logic            neg_q_reg,  neg_q_next;
    logic            neg_r_reg,  neg_r_next;

    logic [XLEN-1:0] lhs, rhs, alu_res;
    logic [SHW-1:0]  shamt;
    logic            accept;

    assign lhs   = bus.rs1;
    assign rhs   = bus.src_sel ? bus.imm : bus.rs2;
    assign shamt = rhs[SHW-1:0];

    assign bus.in_ready  = (state_reg == S_IDLE) ||
                           ((state_reg == S_DONE) && bus.out_ready);
    assign bus.out_valid = (state_reg == S_DONE);
    assign bus.busy      = (state_reg == S_BUSY);
    assign bus.result    = result_reg;
    assign accept        = bus.in_valid && bus.in_ready;

    // Single-cycle ALU
    always_comb begin
        alu_res = '0;
        case (bus.op)
            4'd0: alu_res = lhs + rhs;
            4'd1: alu_res = lhs - rhs;
            4'd2: alu_res = (lhs == rhs) ? XLEN'(0) :
                            (lhs > rhs)  ? XLEN'(2) : XLEN'(4);
            4'd3: alu_res = (lhs == rhs) ? XLEN'(0) :
                            ($signed(lhs) > $signed(rhs)) ? XLEN'(2) : XLEN'(4);
            4'd4: alu_res = lhs >> shamt;
            4'd5: alu_res = $unsigned($signed(lhs) >>> shamt);
            4'd6: alu_res = lhs << shamt;
            4'd7: alu_res = lhs ^ rhs;
            4'd8: alu_res = lhs & rhs;
            4'd9: alu_res = lhs | rhs;
            default: alu_res = '0;
        endcase
    end

    // One MDU iteration
    logic [XLEN:0]   mul_sum, div_trial;
    logic [XLEN-1:0] it_hi, it_lo, mdu_res;
    logic            op_is_mul;

    assign op_is_mul = (op_reg[3:1] == 3'b101);

    always_comb begin
        mul_sum   = {1'b0, acc_hi_reg} + (acc_lo_reg[0] ? {1'b0, opnd_reg} : '0);
        div_trial = {acc_hi_reg, acc_lo_reg[XLEN-1]} - {1'b0, opnd_reg};
        if (op_is_mul) begin
            // Add multiplicand when the current multiplier bit is set, then
            // shift the whole {carry, hi, lo} right by one.
            it_hi = mul_sum[XLEN:1];
            it_lo = {mul_sum[0], acc_lo_reg[XLEN-1:1]};
        end else if (div_trial[XLEN]) begin
            // Trial subtraction went negative: restore (just shift).
            it_hi = {acc_hi_reg[XLEN-2:0], acc_lo_reg[XLEN-1]};
            it_lo = {acc_lo_reg[XLEN-2:0], 1'b0};
        end else begin
            it_hi = div_trial[XLEN-1:0];
            it_lo = {acc_lo_reg[XLEN-2:0], 1'b1};
        end

        case (op_reg)
            4'd10:   mdu_res = it_lo;
            4'd11:   mdu_res = it_hi;
            4'd12:   mdu_res = it_lo;
            4'd13:   mdu_res = it_hi;
            4'd14:   mdu_res = neg_q_reg ? (-it_lo) : it_lo;
            4'd15:   mdu_res = neg_r_reg ? (-it_hi) : it_hi;
            default: mdu_res = '0;
        endcase
    end

    // Issue-side divide decode
    logic            div_signed, div_rem, lhs_neg, rhs_neg;
    logic [XLEN-1:0] lhs_mag, rhs_mag;

    assign div_signed = bus.op[1];
    assign div_rem    = bus.op[0];
    assign lhs_neg    = div_signed && lhs[XLEN-1];
    assign rhs_neg    = div_signed && rhs[XLEN-1];
    assign lhs_mag    = lhs_neg ? (-lhs) : lhs;
    assign rhs_mag    = rhs_neg ? (-rhs) : rhs;

    // Next-state / datapath control
    always_comb begin
        state_next  = state_reg;
        result_next = result_reg;
        count_next  = count_reg;
        acc_hi_next = acc_hi_reg;
        acc_lo_next = acc_lo_reg;
        opnd_next   = opnd_reg;
        op_next     = op_reg;
        neg_q_next  = neg_q_reg;
        neg_r_next  = neg_r_reg;

        if (accept) begin
            op_next    = bus.op;
            count_next = '0;
            if (bus.op < 4'd10) begin
                result_next = alu_res;
                state_next  = S_DONE;
            end else if (!MDU_EN) begin
                result_next = '0;
                state_next  = S_DONE;
            end else if (bus.op[3:1] == 3'b101) begin
                acc_hi_next = '0;
                acc_lo_next = rhs;
                opnd_next   = lhs;
                state_next  = S_BUSY;
            end else if (rhs == '0) begin
                // Divide by zero resolves immediately.
                result_next = div_rem ? lhs : ONES_VAL;
                state_next  = S_DONE;
            end else if (div_signed && (lhs == MIN_VAL) && (rhs == ONES_VAL)) begin
                // Signed overflow also resolves immediately.
                result_next = div_rem ? '0 : lhs;
                state_next  = S_DONE;
            end else begin
                acc_hi_next = '0;
                acc_lo_next = lhs_mag;
                opnd_next   = rhs_mag;
                neg_q_next  = lhs_neg ^ rhs_neg;
                neg_r_next  = lhs_neg;
                state_next  = S_BUSY;
            end
        end else begin
            case (state_reg)
                S_BUSY: begin
                    acc_hi_next = it_hi;
                    acc_lo_next = it_lo;
                    count_next  = count_reg + 1'b1;
                    if (count_reg == CW'(XLEN - 1)) begin
                        result_next = mdu_res;
                        count_next  = '0;
                        state_next  = S_DONE;
                    end
                end
                S_DONE: begin
                    if (bus.out_ready) begin
                        state_next = S_IDLE;
                    end
                end
                default: ;
            endcase
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_reg  <= S_IDLE;
            result_reg <= '0;
            count_reg  <= '0;
            acc_hi_reg <= '0;
            acc_lo_reg <= '0;
            opnd_reg   <= '0;
            op_reg     <= '0;
            neg_q_reg  <= 1'b0;
            neg_r_reg  <= 1'b0;
        end else begin
            state_reg  <= state_next;
            result_reg <= result_next;
            count_reg  <= count_next;
            acc_hi_reg <= acc_hi_next;
            acc_lo_reg <= acc_lo_next;
            opnd_reg   <= opnd_next;
            op_reg     <= op_next;
            neg_q_reg  <= neg_q_next;
            neg_r_reg  <= neg_r_next;
        end
    end

endmodule
